mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports wb_en_in, mem_r_en, mem_w_en  input  1 each  control bits from the EXE/MEM register.
REQ-004 SHALL have ports alu_res  input  16  word address or ALU result; st_val  input  16  store data.
REQ-005 SHALL have port dest_in  input  4  writeback register index.
REQ-006 SHALL have ports sram_rdata  input  16  read data; sram_ready  input  1  access-complete strobe.
REQ-007 SHALL have ports sram_req, sram_we  output  1 each; sram_addr, sram_wdata  output  16 each.
REQ-008 SHALL have port freeze  output  1  holds the PC, IF/ID, ID/EXE and EXE/MEM registers.
REQ-009 SHALL have ports wb_en_out, mem_r_en_out  output  1 each; alu_res_out, mem_rdata  output  16 each; dest_out  output  4; all toward MEM/WB.
REQ-010 SHALL have port err  output  1  sticky timeout flag; present only with SRAM_TIMEOUT_EN.

Function
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-012 IDLE, mem_r_en=mem_w_en=0: freeze=0; outputs pass through combinationally; mem_rdata=0; state stays IDLE.
REQ-013 IDLE, mem_r_en|mem_w_en=1: freeze=1 the same cycle; next edge registers sram_addr=alu_res, sram_wdata=st_val, sram_we=mem_w_en; state goes to ACCESS.
REQ-014 Simultaneous mem_r_en and mem_w_en SHALL be treated as a write (sram_we=1).
REQ-015 ACCESS: sram_req=1 and freeze=1; sram_addr, sram_wdata and sram_we SHALL stay stable until sram_ready is sampled high.
REQ-016 ACCESS with sram_ready=1: next edge captures sram_rdata into rdata_q (reads only; writes leave rdata_q unchanged) and moves to DONE; sram_req is low in DONE.
REQ-017 sram_ready SHALL be ignored outside ACCESS.
REQ-018 DONE: freeze=0 for exactly one cycle; mem_rdata=rdata_q; the other outputs pass through; next state is IDLE unconditionally.
REQ-019 DONE SHALL NOT reissue an access even though mem_r_en/mem_w_en are still asserted; the held instruction retires at the end of DONE.
REQ-020 Minimum memory-instruction latency SHALL be 3 cycles (IDLE, ACCESS, DONE) with sram_ready high on the first ACCESS cycle; each extra ACCESS cycle adds one.
REQ-021 Back-to-back memory instructions SHALL each run a full IDLE, ACCESS, DONE sequence.
REQ-022 mem_r_en_out SHALL equal mem_r_en and wb_en_out SHALL equal wb_en_in, both gated to 0 while freeze=1.

Reset
REQ-023 rst SHALL force state=IDLE and clear sram_req, sram_we, sram_addr, sram_wdata, rdata_q, the timeout counter and err on the next edge, including mid-ACCESS.
REQ-024 After reset, freeze SHALL be 0 until a memory instruction is presented.

Configuration
REQ-025 With SRAM_TIMEOUT_EN defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without sram_ready.
REQ-026 When the counter reaches 255 without sram_ready, the FSM SHALL go to DONE, load rdata_q=0, and set err=1, which stays set until rst.
REQ-027 Without SRAM_TIMEOUT_EN: no counter, no err port; ACCESS waits indefinitely.

Verification
REQ-028 Read: alu_res=0x0040, mem_r_en=1, sram_ready on the first ACCESS cycle with sram_rdata=0xBEEF -> freeze high for 2 cycles; mem_rdata=0xBEEF and wb_en_out=1 in DONE.
REQ-029 Write: alu_res=0x0012, st_val=0x1234, mem_w_en=1, sram_ready delayed by 4 cycles -> sram_we=1 and address/data held for 5 ACCESS cycles; freeze high for 6 cycles.
REQ-030 ALU op (no mem enables), alu_res=0x00AA -> freeze=0; alu_res_out=0x00AA the same cycle.
REQ-031 Reset on the 2nd ACCESS cycle -> sram_req=0 and state IDLE after the edge; rdata_q=0; a subsequent read completes normally.
REQ-032 SRAM_TIMEOUT_EN, sram_ready never asserted -> DONE after 255 ACCESS cycles; mem_rdata=0; err=1 and still set after 10 more cycles.
REQ-033 Two consecutive reads (0x0001, 0x0002) with immediate sram_ready -> two separate 3-cycle sequences; exactly two sram_req pulses.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage SRAM handshake controller with pipeline freeze.
// Define SRAM_TIMEOUT_EN to add an access watchdog and a sticky err output.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [15:0] alu_res,
  input  logic [15:0] st_val,
  input  logic [3:0]  dest_in,
  input  logic [15:0] sram_rdata,
  input  logic        sram_ready,
  output logic        sram_req,
  output logic        sram_we,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_wdata,
  output logic        freeze,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [15:0] alu_res_out,
  output logic [15:0] mem_rdata,
  output logic [3:0]  dest_out
`ifdef SRAM_TIMEOUT_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_sram_req;
  logic        r_sram_we;
  logic [15:0] r_sram_addr;
  logic [15:0] r_sram_wdata;
  logic [15:0] r_rdata_q;
  logic        w_mem;
  logic        w_timeout;

  assign w_mem = mem_r_en | mem_w_en;

`ifdef SRAM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  // Give up on the 255th ACCESS cycle without a ready strobe.
  assign w_timeout = (r_state == S_ACCESS) && !sram_ready
                     && (r_cnt == 8'd254);
  assign err = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && w_mem) begin
      r_cnt <= 8'd0;
    end else if (r_state == S_ACCESS && !sram_ready) begin
      r_cnt <= r_cnt + 8'd1;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sram_req   <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= 16'h0000;
      r_sram_wdata <= 16'h0000;
      r_rdata_q    <= 16'h0000;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mem) begin
            r_state      <= S_ACCESS;
            r_sram_req   <= 1'b1;
            r_sram_we    <= mem_w_en;
            r_sram_addr  <= alu_res;
            r_sram_wdata <= st_val;
          end
        end
        S_ACCESS: begin
          if (sram_ready) begin
            r_state    <= S_DONE;
            r_sram_req <= 1'b0;
            if (!r_sram_we)
              r_rdata_q <= sram_rdata;
          end else if (w_timeout) begin
            r_state    <= S_DONE;
            r_sram_req <= 1'b0;
            r_rdata_q  <= 16'h0000;
          end
        end
        S_DONE: begin
          // The held instruction retires here; never reissue.
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign freeze = (r_state == S_ACCESS)
                | ((r_state == S_IDLE) & w_mem);

  assign sram_req     = r_sram_req;
  assign sram_we      = r_sram_we;
  assign sram_addr    = r_sram_addr;
  assign sram_wdata   = r_sram_wdata;
  assign wb_en_out    = wb_en_in & ~freeze;
  assign mem_r_en_out = mem_r_en & ~freeze;
  assign alu_res_out  = alu_res;
  assign dest_out     = dest_in;
  assign mem_rdata    = (r_state == S_DONE) ? r_rdata_q : 16'h0000;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl with an SRAM responder.
// Timeout checks are compiled in when SRAM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en_in = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [15:0] alu_res = 16'h0;
  logic [15:0] st_val = 16'h0;
  logic [3:0]  dest_in = 4'h0;
  logic [15:0] sram_rdata = 16'h0;
  logic        sram_ready = 1'b0;
  logic        sram_req;
  logic        sram_we;
  logic [15:0] sram_addr;
  logic [15:0] sram_wdata;
  logic        freeze;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [15:0] alu_res_out;
  logic [15:0] mem_rdata;
  logic [3:0]  dest_out;
`ifdef SRAM_TIMEOUT_EN
  logic        err;
`endif

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .alu_res      (alu_res),
    .st_val       (st_val),
    .dest_in      (dest_in),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready),
    .sram_req     (sram_req),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .freeze       (freeze),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_rdata    (mem_rdata),
`ifdef SRAM_TIMEOUT_EN
    .err          (err),
`endif
    .dest_out     (dest_out)
  );

  typedef struct {
    logic        wb;
    logic        rd;
    logic [15:0] alu;
    logic [3:0]  dst;
    logic [15:0] rdata;
    int          lat;
  } ret_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          dly;
  } acc_t;

  ret_t ret_q[$];
  acc_t acc_q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  int   req_pulses = 0;
  logic prev_req = 1'b0;
  logic [15:0] last_rd = 16'h0;
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] sram_mem  [logic [15:0]];

  function automatic logic [15:0] seed_val(input logic [15:0] a);
    return (a * 16'd37) ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h need %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pipeline model: one instruction at a time, held while freeze is high.
  task automatic issue(input logic r, input logic w, input logic wb,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic [3:0] dst, input int dly);
    ret_t e;
    acc_t x;
    int   n;
    e.wb = wb; e.rd = r; e.alu = a; e.dst = dst;
    e.rdata = 16'h0; e.lat = 0;
    if (r || w) begin
      x.addr = a; x.we = w; x.wdata = d; x.dly = dly;
      acc_q.push_back(x);
      e.lat = (dly >= 255) ? 256 : 2 + dly;
      if (dly >= 255) begin
        last_rd = 16'h0;
      end else if (w) begin
        model_mem[a] = d;
      end else begin
        last_rd = model_mem.exists(a) ? model_mem[a] : seed_val(a);
      end
      e.rdata = last_rd;
    end
    ret_q.push_back(e);
    wb_en_in = wb; mem_r_en = r; mem_w_en = w;
    alu_res = a; st_val = d; dest_in = dst;
    n = 0;
    forever begin
      @(negedge clk);
      if (!freeze) break;
      n++;
      if (n > 400) begin
        $display("FAIL retire_wait: got no retire need retire");
        $fatal(1, "stuck");
      end
    end
    @(posedge clk); #1;
  endtask

  int   frz_cnt = 0;
  ret_t m_e;
  always @(negedge clk) begin
    if (!chk_en || rst) begin
      frz_cnt = 0;
    end else if (freeze) begin
      frz_cnt++;
      check("gate_wb", {31'd0, wb_en_out}, 32'd0);
      check("gate_rd", {31'd0, mem_r_en_out}, 32'd0);
    end else if (ret_q.size() > 0) begin
      m_e = ret_q.pop_front();
      check("wb_en_out", {31'd0, wb_en_out}, {31'd0, m_e.wb});
      check("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, m_e.rd});
      check("alu_res_out", {16'd0, alu_res_out}, {16'd0, m_e.alu});
      check("dest_out", {28'd0, dest_out}, {28'd0, m_e.dst});
      check("mem_rdata", {16'd0, mem_rdata}, {16'd0, m_e.rdata});
      check("freeze_cycles", frz_cnt, m_e.lat);
      frz_cnt = 0;
    end
  end

  acc_t r_cur;
  bit   r_act = 1'b0;
  int   r_wait = 0;
  always @(negedge clk) begin
    if (!chk_en || rst) begin
      r_act = 1'b0;
      sram_ready = 1'b0;
    end else if (sram_req) begin
      if (!r_act) begin
        r_act = 1'b1;
        r_wait = 0;
        if (acc_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
          r_cur.addr = sram_addr; r_cur.we = sram_we;
          r_cur.wdata = sram_wdata; r_cur.dly = 0;
        end else begin
          r_cur = acc_q.pop_front();
        end
        check("sram_addr", {16'd0, sram_addr}, {16'd0, r_cur.addr});
        check("sram_we", {31'd0, sram_we}, {31'd0, r_cur.we});
        check("sram_wdata", {16'd0, sram_wdata}, {16'd0, r_cur.wdata});
      end else begin
        check("hold_addr", {16'd0, sram_addr}, {16'd0, r_cur.addr});
        check("hold_we", {31'd0, sram_we}, {31'd0, r_cur.we});
        check("hold_wdata", {16'd0, sram_wdata}, {16'd0, r_cur.wdata});
      end
      sram_rdata = sram_mem.exists(sram_addr) ? sram_mem[sram_addr]
                                              : seed_val(sram_addr);
      if (r_wait == r_cur.dly) begin
        sram_ready = 1'b1;
        if (sram_we) sram_mem[sram_addr] = sram_wdata;
      end else begin
        sram_ready = 1'b0;
        r_wait++;
      end
    end else begin
      // Noise outside an access must be ignored.
      r_act = 1'b0;
      sram_ready = 1'($urandom_range(0, 1));
      sram_rdata = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (sram_req === 1'b1 && prev_req !== 1'b1) req_pulses++;
    prev_req = sram_req;
  end

  int p0;
  initial begin
    model_mem[16'h0040] = 16'hBEEF;
    sram_mem[16'h0040]  = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_freeze", {31'd0, freeze}, 32'd0);
    check("rst_req", {31'd0, sram_req}, 32'd0);
    check("rst_we", {31'd0, sram_we}, 32'd0);
    check("rst_addr", {16'd0, sram_addr}, 32'd0);
    check("rst_wdata", {16'd0, sram_wdata}, 32'd0);
    check("rst_rdata", {16'd0, mem_rdata}, 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b1;

    issue(1'b0, 1'b0, 1'b1, 16'h00AA, 16'h0000, 4'h3, 0);
    issue(1'b1, 1'b0, 1'b1, 16'h0040, 16'h0000, 4'h5, 0);
    issue(1'b0, 1'b1, 1'b0, 16'h0012, 16'h1234, 4'h0, 4);
    p0 = req_pulses;
    issue(1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000, 4'h1, 0);
    issue(1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000, 4'h2, 0);
    check("two_pulses", req_pulses - p0, 2);

    // Abort a read on its second ACCESS cycle.
    chk_en = 1'b0;
    wb_en_in = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0;
    alu_res = 16'h0050;
    @(posedge clk); #1;
    check("abort_req_on", {31'd0, sram_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_r_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_req", {31'd0, sram_req}, 32'd0);
    check("abort_idle", {31'd0, freeze}, 32'd0);
    check("abort_addr", {16'd0, sram_addr}, 32'd0);
    last_rd = 16'h0;
    chk_en = 1'b1;
    issue(1'b0, 1'b1, 1'b1, 16'h0060, 16'h5A5A, 4'h6, 1);
    issue(1'b1, 1'b0, 1'b1, 16'h0060, 16'h0000, 4'h7, 1);

    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 3);
      issue(1'(k == 1 || k == 3), 1'(k >= 2), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 7)), 16'($urandom),
            4'($urandom_range(0, 15)), $urandom_range(0, 4));
    end

`ifdef SRAM_TIMEOUT_EN
    check("err_clear", {31'd0, err}, 32'd0);
    issue(1'b1, 1'b0, 1'b1, 16'h0070, 16'h0000, 4'h1, 100000);
    check("err_set", {31'd0, err}, 32'd1);
    wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("err_sticky", {31'd0, err}, 32'd1);
`endif

    wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ret_q_empty", ret_q.size(), 0);
    check("acc_q_empty", acc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
